jtframe_rom_arb: RTL and testbench

Parametrised N-slot SDRAM read arbiter with a one-line 32-bit cache per slot, sitting between game-level ROM clients (main CPU, sound CPU, GFX fetchers) and the single SDRAM read port. It generalises the fixed-slot ROM front end:

- Slot count and per-slot offsets are parameters.
- Arbitration is fixed-priority or round-robin.
- Cache is flushed and transactions aborted on download.

---
 rtl/jtframe_rom_arb.sv | 194 +++++++++++++++++++
 tb/tb_jtframe_rom_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_rom_arb.sv
// ============================================================================
// Module   : jtframe_rom_arb
// Purpose  : N-slot SDRAM read arbiter. Each client slot owns a one-line,
//            32-bit cache (an even/odd word pair). A miss is forwarded to the
//            single SDRAM read port. A ROM download flushes every line and
//            aborts any transaction in flight.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            downloading         - ROM download active: flush and abort
//            slot_cs/slot_addr   - per-slot request and word address
//            slot_dout/slot_ok   - per-slot data and valid (0-cycle on hit)
//            sdram_req/sdram_ack - request handshake to the SDRAM controller
//            sdram_addr          - even SDRAM word address of the line
//            data_rdy/data_read  - returned 32-bit line
//            refresh_en          - arbiter idle, refresh may proceed
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtframe_rom_arb #(
    parameter int                  SLOTS       = 4,
    parameter int                  AW          = 18,
    parameter logic [SLOTS*22-1:0] OFFSETS     = '0,
    parameter int                  ROUND_ROBIN = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  downloading,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS*16-1:0]   slot_dout,
    output logic [SLOTS-1:0]      slot_ok,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    input  logic                  data_rdy,
    output logic [21:0]           sdram_addr,
    input  logic [31:0]           data_read,
    output logic                  refresh_en
);

    localparam int LW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          r_state, w_state_nx;
    logic [LW-1:0]   r_gslot, w_gslot_nx;
    logic [LW-1:0]   r_last,  w_last_nx;
    logic [AW-2:0]   r_gaddr, w_gaddr_nx;
    logic            r_req,   w_req_nx;
    logic [21:0]     r_saddr, w_saddr_nx;
    logic            w_fill;

    logic [SLOTS-1:0] r_valid;
    logic [AW-2:0]    r_tag  [SLOTS];
    logic [31:0]      r_line [SLOTS];
    logic [AW-1:0]    w_addr [SLOTS];
    logic [21:0]      w_off  [SLOTS];
    logic [SLOTS-1:0] w_hit;
    logic [SLOTS-1:0] w_miss;

    // ------------------------------------------------------------------
    // Per-slot cache line, hit detection and read-data mux
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < SLOTS; k++) begin : g_slot
            assign w_addr[k]  = slot_addr[AW*k +: AW];
            assign w_off[k]   = OFFSETS[22*k +: 22];
            assign w_hit[k]   = r_valid[k] && (r_tag[k] == w_addr[k][AW-1:1]);
            assign w_miss[k]  = slot_cs[k] & ~w_hit[k];
            assign slot_ok[k] = slot_cs[k] & w_hit[k] & ~downloading;
            assign slot_dout[16*k +: 16] = w_addr[k][0] ? r_line[k][31:16]
                                                        : r_line[k][15:0];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[k] <= 1'b0;
                    r_tag[k]   <= '0;
                    r_line[k]  <= '0;
                end else if (downloading) begin
                    r_valid[k] <= 1'b0;
                end else if (w_fill && (r_gslot == LW'(k))) begin
                    // Tag comes from the captured address, not the live one,
                    // so a client that moved on stays a miss.
                    r_valid[k] <= 1'b1;
                    r_tag[k]   <= r_gaddr;
                    r_line[k]  <= data_read;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Grant selection. Fixed priority is the rotating search pinned to a
    // base of SLOTS-1, so slot 0 is always examined first.
    // ------------------------------------------------------------------
    logic [LW-1:0] w_base, w_grant, w_idx;
    logic          w_found;

    always_comb begin
        w_base  = (ROUND_ROBIN != 0) ? r_last : LW'(SLOTS - 1);
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= SLOTS; i++) begin
            w_idx = LW'((int'(w_base) + i) % SLOTS);
            if (!w_found && w_miss[w_idx]) begin
                w_grant = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM: next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_gslot_nx = r_gslot;
        w_last_nx  = r_last;
        w_gaddr_nx = r_gaddr;
        w_req_nx   = r_req;
        w_saddr_nx = r_saddr;
        w_fill     = 1'b0;
        if (downloading) begin
            // Abort wins over every other transition; late data is dropped.
            w_state_nx = IDLE;
            w_req_nx   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        w_gslot_nx = w_grant;
                        w_last_nx  = w_grant;
                        w_gaddr_nx = w_addr[w_grant][AW-1:1];
                        w_saddr_nx = w_off[w_grant] +
                                     22'({w_addr[w_grant][AW-1:1], 1'b0});
                        w_req_nx   = 1'b1;
                        w_state_nx = REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        w_req_nx = 1'b0;
                        // Controller may return data in the ack cycle itself.
                        if (data_rdy) begin
                            w_fill     = 1'b1;
                            w_state_nx = IDLE;
                        end else begin
                            w_state_nx = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (data_rdy) begin
                        w_fill     = 1'b1;
                        w_state_nx = IDLE;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gslot <= '0;
            r_last  <= LW'(SLOTS - 1);
            r_gaddr <= '0;
            r_req   <= 1'b0;
            r_saddr <= '0;
        end else begin
            r_state <= w_state_nx;
            r_gslot <= w_gslot_nx;
            r_last  <= w_last_nx;
            r_gaddr <= w_gaddr_nx;
            r_req   <= w_req_nx;
            r_saddr <= w_saddr_nx;
        end
    end

    assign sdram_req  = r_req;
    assign sdram_addr = r_saddr;
    assign refresh_en = (r_state == IDLE) & ~(|w_miss);

endmodule

`default_nettype wire

// File: tb/tb_jtframe_rom_arb.sv
// ============================================================================
// Module   : tb_jtframe_rom_arb
// Purpose  : Self-checking bench for jtframe_rom_arb. Two instances share
//            all inputs: one fixed-priority, one round-robin. A per-cycle
//            vector table covers the basic miss/hit flow; hand-written
//            sequences cover priority, round robin, download abort, address
//            change in flight and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtframe_rom_arb;

    localparam logic [87:0] OFFS = {22'h30000, 22'h20000, 22'h10000, 22'h00000};

    logic        clk;
    logic        rst_n;
    logic        downloading;
    logic [3:0]  slot_cs;
    logic [71:0] slot_addr;
    logic        sdram_ack;
    logic        data_rdy;
    logic [31:0] data_read;
    logic [17:0] sa [4];

    logic [63:0] fx_dout, rr_dout;
    logic [3:0]  fx_ok, rr_ok;
    logic        fx_req, rr_req;
    logic [21:0] fx_addr, rr_addr;
    logic        fx_ref, rr_ref;

    int n_tests = 0;
    int n_fail  = 0;

    assign slot_addr = {sa[3], sa[2], sa[1], sa[0]};

    jtframe_rom_arb #(.SLOTS(4), .AW(18), .OFFSETS(OFFS), .ROUND_ROBIN(0)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_dout(fx_dout), .slot_ok(fx_ok),
        .sdram_req(fx_req), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
        .sdram_addr(fx_addr), .data_read(data_read), .refresh_en(fx_ref)
    );

    jtframe_rom_arb #(.SLOTS(4), .AW(18), .OFFSETS(OFFS), .ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_dout(rr_dout), .slot_ok(rr_ok),
        .sdram_req(rr_req), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
        .sdram_addr(rr_addr), .data_read(data_read), .refresh_en(rr_ref)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dl;
        logic [3:0]  cs;
        logic [17:0] a1;
        logic [17:0] a2;
        logic        ack;
        logic        rdy;
        logic [31:0] data;
        logic        ereq;
        logic [21:0] eaddr;
        logic [3:0]  eok;
        logic [63:0] edout;
        logic        eref;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic [3:0] cs, input logic [17:0] a1,
                                input logic [17:0] a2, input logic ack,
                                input logic rdy, input logic [31:0] data,
                                input logic ereq, input logic [21:0] eaddr,
                                input logic [3:0] eok, input logic [63:0] edout,
                                input logic eref);
        vec_t v;
        v.dl = 1'b0; v.cs = cs; v.a1 = a1; v.a2 = a2; v.ack = ack; v.rdy = rdy;
        v.data = data; v.ereq = ereq; v.eaddr = eaddr; v.eok = eok;
        v.edout = edout; v.eref = eref;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, check its address, ack it, return data.
    // Returns one cycle after data_rdy, when the filled slot should hit.
    task automatic serve(input bit sel, input logic [21:0] ea,
                         input logic [31:0] d, input string nm);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 16 && !found; n++) begin
            if ((sel ? rr_req : fx_req) === 1'b1) found = 1'b1;
            else tick();
        end
        chk({nm, " req seen"}, {63'd0, found}, 64'd1);
        chk({nm, " addr"}, {42'd0, (sel ? rr_addr : fx_addr)}, {42'd0, ea});
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b1;
        data_read = d;
        tick();
        data_rdy  = 1'b0;
        #1;
    endtask

    logic [21:0] rexp [4];

    initial begin
        rst_n = 1'b0; downloading = 1'b0; slot_cs = '0; sdram_ack = 1'b0;
        data_rdy = 1'b0; data_read = '0;
        for (int i = 0; i < 4; i++) sa[i] = '0;

        //           cs     a1  a2  ack rdy data           req eaddr     ok     dout                    ref
        tbl[0]  = mk(4'h0, 0,  0,  0,  0,  32'h0,         0, 22'h00000, 4'h0, 64'h0,                  1);
        tbl[1]  = mk(4'h2, 5,  0,  0,  0,  32'h0,         0, 22'h00000, 4'h0, 64'h0,                  0);
        tbl[2]  = mk(4'h2, 5,  0,  0,  0,  32'h0,         1, 22'h10004, 4'h0, 64'h0,                  0);
        tbl[3]  = mk(4'h2, 5,  0,  0,  0,  32'h0,         1, 22'h10004, 4'h0, 64'h0,                  0);
        tbl[4]  = mk(4'h2, 5,  0,  1,  0,  32'h0,         1, 22'h10004, 4'h0, 64'h0,                  0);
        tbl[5]  = mk(4'h2, 5,  0,  0,  0,  32'h0,         0, 22'h10004, 4'h0, 64'h0,                  0);
        tbl[6]  = mk(4'h2, 5,  0,  0,  1,  32'hBEEF1234,  0, 22'h10004, 4'h0, 64'h0,                  0);
        tbl[7]  = mk(4'h2, 5,  0,  0,  0,  32'h0,         0, 22'h10004, 4'h2, 64'h0000_0000_BEEF_0000, 1);
        tbl[8]  = mk(4'h2, 4,  0,  0,  0,  32'h0,         0, 22'h10004, 4'h2, 64'h0000_0000_1234_0000, 1);
        tbl[9]  = mk(4'h2, 4,  0,  0,  0,  32'h0,         0, 22'h10004, 4'h2, 64'h0000_0000_1234_0000, 1);
        tbl[10] = mk(4'h4, 4,  0,  0,  1,  32'hFFFFFFFF,  0, 22'h10004, 4'h0, 64'h0000_0000_1234_0000, 0);
        tbl[11] = mk(4'h4, 4,  0,  0,  1,  32'hFFFFFFFF,  1, 22'h20000, 4'h0, 64'h0000_0000_1234_0000, 0);
        tbl[12] = mk(4'h4, 4,  0,  1,  1,  32'hCAFE5678,  1, 22'h20000, 4'h0, 64'h0000_0000_1234_0000, 0);
        tbl[13] = mk(4'h4, 4,  0,  0,  0,  32'h0,         0, 22'h20000, 4'h4, 64'h0000_5678_1234_0000, 1);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ---------------- per-cycle vector table ----------------
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            downloading = tbl[i].dl; slot_cs = tbl[i].cs;
            sa[1] = tbl[i].a1; sa[2] = tbl[i].a2;
            sdram_ack = tbl[i].ack; data_rdy = tbl[i].rdy; data_read = tbl[i].data;
            #2;
            chk($sformatf("row%0d sdram_req", i),  {63'd0, fx_req}, {63'd0, tbl[i].ereq});
            chk($sformatf("row%0d sdram_addr", i), {42'd0, fx_addr}, {42'd0, tbl[i].eaddr});
            chk($sformatf("row%0d slot_ok", i),    {60'd0, fx_ok}, {60'd0, tbl[i].eok});
            chk($sformatf("row%0d slot_dout", i),  fx_dout, tbl[i].edout);
            chk($sformatf("row%0d refresh_en", i), {63'd0, fx_ref}, {63'd0, tbl[i].eref});
        end
        @(posedge clk);
        #1;
        sdram_ack = 1'b0; data_rdy = 1'b0;

        // ---------------- fixed priority: 0, 2, 3 ----------------
        sa[0] = 18'h100; sa[2] = 18'h200; sa[3] = 18'h300;
        slot_cs = 4'b1101;
        serve(1'b0, 22'h00100, 32'h1111_0A00, "prio g0");
        chk("prio refresh after g0", {63'd0, fx_ref}, 64'd0);
        serve(1'b0, 22'h20200, 32'h2222_0B00, "prio g1");
        chk("prio refresh after g1", {63'd0, fx_ref}, 64'd0);
        serve(1'b0, 22'h30300, 32'h3333_0C00, "prio g2");
        chk("prio refresh final", {63'd0, fx_ref}, 64'd1);
        chk("prio ok final", {60'd0, fx_ok}, {60'd0, 4'b1101});
        chk("prio dout final", fx_dout, 64'h0C00_0B00_1234_0A00);

        // ---------------- download abort in WAIT ----------------
        slot_cs = 4'b0001; sa[0] = 18'h500;
        tick();
        chk("dl req", {63'd0, fx_req}, 64'd1);
        chk("dl addr", {42'd0, fx_addr}, {42'd0, 22'h00500});
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        chk("dl req low in wait", {63'd0, fx_req}, 64'd0);
        downloading = 1'b1; data_rdy = 1'b1; data_read = 32'hDEAD_BEEF;
        tick();
        data_rdy = 1'b0;
        chk("dl req during dl", {63'd0, fx_req}, 64'd0);
        chk("dl ok during dl", {60'd0, fx_ok}, 64'd0);
        tick();
        chk("dl req held idle", {63'd0, fx_req}, 64'd0);
        downloading = 1'b0; sa[0] = 18'h100;
        #1;
        chk("dl flushed old line", {60'd0, fx_ok}, 64'd0);
        sa[0] = 18'h500;
        #1;
        chk("dl late data dropped", {60'd0, fx_ok}, 64'd0);
        tick();
        serve(1'b0, 22'h00500, 32'h5555_6666, "dl rerequest");
        chk("dl refill ok", {63'd0, fx_ok[0]}, 64'd1);
        chk("dl refill dout", {48'd0, fx_dout[15:0]}, 64'h6666);

        // ---------------- address change while in REQ ----------------
        sa[0] = 18'h010;
        tick();
        chk("ac req", {63'd0, fx_req}, 64'd1);
        chk("ac addr", {42'd0, fx_addr}, {42'd0, 22'h00010});
        sa[0] = 18'h020; sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0; data_rdy = 1'b1; data_read = 32'h7777_8888;
        tick();
        data_rdy = 1'b0;
        #1;
        chk("ac stale fill no ok", {63'd0, fx_ok[0]}, 64'd0);
        tick();
        chk("ac second req", {63'd0, fx_req}, 64'd1);
        serve(1'b0, 22'h00020, 32'h9999_AAAA, "ac second");
        chk("ac second ok", {63'd0, fx_ok[0]}, 64'd1);
        chk("ac second dout", {48'd0, fx_dout[15:0]}, 64'hAAAA);
        sa[0] = 18'h010;
        #1;
        chk("ac back to 0x10 miss", {63'd0, fx_ok[0]}, 64'd0);
        tick();
        serve(1'b0, 22'h00010, 32'h1234_5678, "ac third");
        slot_cs = 4'b0000;

        // ---------------- async reset mid-REQ ----------------
        sa[0] = 18'h030; slot_cs = 4'b0001;
        tick();
        chk("rst req before", {63'd0, fx_req}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst req immediate", {63'd0, fx_req}, 64'd0);
        chk("rst addr immediate", {42'd0, fx_addr}, 64'd0);
        chk("rst ok immediate", {60'd0, fx_ok}, 64'd0);
        slot_cs = 4'b0000;
        tick();
        rst_n = 1'b1; data_rdy = 1'b1; data_read = 32'h1357_9BDF;
        tick();
        data_rdy = 1'b0; slot_cs = 4'b0001;
        #1;
        chk("rst late data no ok", {60'd0, fx_ok}, 64'd0);
        chk("rst lines cleared", fx_dout, 64'd0);
        slot_cs = 4'b0000;

        // ---------------- round robin: grants alternate 0,1,0,1 ----------------
        rexp[0] = 22'h00040; rexp[1] = 22'h10080; rexp[2] = 22'h00042; rexp[3] = 22'h10082;
        sa[0] = 18'h040; sa[1] = 18'h080;
        slot_cs = 4'b0011;
        for (int j = 0; j < 4; j++) begin
            serve(1'b1, rexp[j], 32'hA000_0000 | 32'(j), $sformatf("rr grant%0d", j));
            chk($sformatf("rr ok%0d", j), {63'd0, rr_ok[j % 2]}, 64'd1);
            sa[j % 2] = sa[j % 2] + 18'd2;
        end
        slot_cs = 4'b0000;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
